// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: AHB transfer/response encodings and bridge FSM states shared by the bridge files
package ahb_apb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  typedef enum logic [2:0] {ST_IDLE, ST_WLATCH, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2} state_t;
  function automatic logic is_active(input logic [1:0] htrans);
    return htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ;
  endfunction
endpackage

// File: rtl/ahb_apb_decoder.sv
// ahb_apb_decoder: slave index to one-hot select plus decode-error flag
//   idx : slave-index field taken from haddr
//   sel : one-hot slave select, all zero on a decode error
//   err : index outside the populated slave range
module ahb_apb_decoder #(
  parameter int NUM_SLAVES = 4
) (
  input  logic [3:0]            idx,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  err
);
  always_comb begin
    err = int'(idx) >= NUM_SLAVES;
    sel = err ? '0 : NUM_SLAVES'(1) << idx;
  end
endmodule

// File: rtl/ahb2apb_bridge_gen2.sv
// ahb2apb_bridge_gen2: single-outstanding AHB-to-APB3 bridge with decode errors and access timeout
//   hclk/hresetn              : clock, synchronous active-low reset
//   hwrite/hreadyin/htrans/haddr/hwdata : AHB request side
//   hrdata/hreadyout/hresp    : registered AHB response side
//   paddr/pwrite/pwdata/penable/pselx   : registered APB request side
//   prdata/pready/pslverr     : APB completer response
module ahb2apb_bridge_gen2
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int REGION_LSB = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hwrite,
  input  logic                  hreadyin,
  input  logic [1:0]            htrans,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic                  penable,
  output logic [NUM_SLAVES-1:0] pselx,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t                state;
  logic [NUM_SLAVES-1:0] sel_d;
  logic [NUM_SLAVES-1:0] sel_q;
  logic                  dec_err;
  logic                  accept;
  logic [CW-1:0]         cnt;
  ahb_apb_decoder #(.NUM_SLAVES(NUM_SLAVES)) u_dec (
    .idx(haddr[REGION_LSB+3:REGION_LSB]),
    .sel(sel_d),
    .err(dec_err)
  );
  // hreadyout is high only in IDLE and ERR2, so it doubles as the "can accept" qualifier
  assign accept = hreadyin && hreadyout && is_active(htrans);
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state     <= ST_IDLE;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      hrdata    <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      penable   <= 1'b0;
      pselx     <= '0;
      sel_q     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: begin
          state     <= ST_IDLE;
          hreadyout <= 1'b1;
          hresp     <= HRESP_OKAY;
          if (accept) begin
            paddr     <= haddr;
            pwrite    <= hwrite;
            sel_q     <= sel_d;
            hreadyout <= 1'b0;
            hresp     <= dec_err ? HRESP_ERROR : HRESP_OKAY;
            state     <= dec_err ? ST_ERR1 : hwrite ? ST_WLATCH : ST_SETUP;
            // reads skip the data-latch cycle and go straight to SETUP
            if (!dec_err && !hwrite) pselx <= sel_d;
          end
        end
        ST_WLATCH: begin
          pwdata <= hwdata;
          pselx  <= sel_q;
          state  <= ST_SETUP;
        end
        ST_SETUP: begin
          penable <= 1'b1;
          cnt     <= '0;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            pselx     <= '0;
            penable   <= 1'b0;
            hreadyout <= !pslverr;
            hresp     <= pslverr ? HRESP_ERROR : HRESP_OKAY;
            state     <= pslverr ? ST_ERR1 : ST_IDLE;
            if (!pslverr && !pwrite) hrdata <= prdata;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // this was the TIMEOUT-th consecutive wait cycle: abandon the APB access
            pselx     <= '0;
            penable   <= 1'b0;
            hreadyout <= 1'b0;
            hresp     <= HRESP_ERROR;
            state     <= ST_ERR1;
          end else if (cnt != CW'(TIMEOUT)) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ERR1: begin
          hreadyout <= 1'b1;
          hresp     <= HRESP_ERROR;
          state     <= ST_ERR2;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb2apb_bridge_gen2.sv
// tb_ahb2apb_bridge_gen2: randomized scoreboard bench for the AHB-to-APB bridge
module tb_ahb2apb_bridge_gen2;
  localparam int TO = 16;
  localparam int NS = 4;
  logic          hclk = 1'b0;
  logic          hresetn = 1'b0;
  logic          hwrite = 1'b0;
  logic          hreadyin = 1'b1;
  logic [1:0]    htrans = 2'b00;
  logic [31:0]   haddr = '0;
  logic [31:0]   hwdata = '0;
  logic [31:0]   hrdata;
  logic          hreadyout;
  logic [1:0]    hresp;
  logic [31:0]   paddr;
  logic          pwrite;
  logic [31:0]   pwdata;
  logic          penable;
  logic [NS-1:0] pselx;
  logic [31:0]   prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        write;
    logic        err;
    logic        decerr;
    logic [NS-1:0] sel;
    int          lat;
    int          acc;
  } exp_t;
  typedef struct {
    int          waits;
    logic        err;
    logic [31:0] rdata;
  } plan_t;

  exp_t  expq[$];
  plan_t planq[$];
  int    n_vec = 0;
  int    n_bad = 0;

  always #5 hclk = ~hclk;

  ahb2apb_bridge_gen2 dut (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hreadyin(hreadyin),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata),
    .hreadyout(hreadyout), .hresp(hresp), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .penable(penable), .pselx(pselx), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one transfer: response, APB select, and cycles from acceptance to hreadyout=1
  function automatic exp_t model(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                                 input int waits, input logic slverr, input logic [31:0] rdata);
    exp_t e;
    int idx;
    idx = int'(addr[15:12]);
    e.addr = addr; e.write = write; e.wdata = wdata; e.rdata = rdata;
    e.decerr = idx >= NS;
    e.sel = '0;
    if (!e.decerr) e.sel[idx] = 1'b1;
    if (e.decerr) begin
      e.err = 1'b1; e.acc = 0; e.lat = 2;
    end else if (waits >= TO) begin
      e.err = 1'b1; e.acc = TO; e.lat = TO + 3 + int'(write);
    end else begin
      e.err = slverr; e.acc = waits + 1; e.lat = waits + 3 + int'(write) + int'(slverr);
    end
    return e;
  endfunction

  task automatic issue(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                       input int waits, input logic slverr, input logic [31:0] rdata);
    exp_t  e;
    plan_t p;
    int    n;
    e = model(addr, write, wdata, waits, slverr, rdata);
    n = 0;
    p.waits = waits; p.err = slverr; p.rdata = rdata;
    if (!e.decerr) planq.push_back(p);
    htrans = {1'b1, 1'($urandom)};
    haddr = addr;
    hwrite = write;
    forever begin
      @(negedge hclk);
      if (hreadyout && hreadyin) break;
      n++;
      if (n > 200) begin
        n_vec++; n_bad++;
        $display("FAIL accept: hreadyout=%0b after 200 cycles, required 1", hreadyout);
        htrans = 2'b00;
        return;
      end
      @(posedge hclk) #1;
      hreadyin = ($urandom_range(0, 7) != 0);
    end
    expq.push_back(e);
    @(posedge hclk) #1;
    hwdata = wdata;
    htrans = {1'b0, 1'($urandom)};
    haddr = $urandom;
    hwrite = 1'($urandom);
    hreadyin = 1'b1;
    @(posedge hclk) #1;
    hwdata = $urandom;
  endtask

  task automatic reset_check();
    @(negedge hclk);
    chk("rst_hreadyout", hreadyout, 1);
    chk("rst_hresp", hresp, 0);
    chk("rst_pselx", pselx, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_hrdata", hrdata, 0);
  endtask

  // APB completer: follows the plan queued for each transfer that reaches SETUP
  initial begin : slave
    plan_t cur;
    int    w;
    cur.waits = 0; cur.err = 1'b0; cur.rdata = '0;
    w = 0;
    forever begin
      @(negedge hclk);
      if (hresetn && pselx != 0 && !penable) begin
        if (planq.size() != 0) cur = planq.pop_front();
        w = 0; pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
      end else if (hresetn && pselx != 0 && w == cur.waits) begin
        pready = 1'b1; prdata = cur.rdata; pslverr = cur.err;
      end else begin
        pready = (pselx != 0) ? 1'b0 : 1'($urandom);
        prdata = $urandom;
        pslverr = 1'($urandom);
        if (pselx != 0) w++;
      end
    end
  end

  // Monitor: tracks each accepted transfer and checks it against the head of the scoreboard
  initial begin : mon
    bit         inflight;
    int         lat, acc, setups;
    logic       prev_rdy;
    logic [1:0] prev_resp;
    exp_t       e;
    inflight = 0; lat = 0; acc = 0; setups = 0; prev_rdy = 1'b1; prev_resp = 2'b00;
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        inflight = 0; prev_rdy = 1'b1; prev_resp = 2'b00;
        continue;
      end
      if (inflight) begin
        lat++;
        if (expq.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL scoreboard: transfer in flight with empty queue, got 0 entries required 1");
          inflight = 0;
        end else begin
          e = expq[0];
          if (pselx != 0) begin
            chk("apb_sel", pselx, e.sel);
            chk("apb_addr", paddr, e.addr);
            chk("apb_write", pwrite, e.write);
            if (e.write) chk("apb_wdata", pwdata, e.wdata);
            if (penable) acc++; else setups++;
          end
          if (hreadyout) begin
            chk("latency", lat, e.lat);
            chk("hresp", hresp, e.err ? 1 : 0);
            chk("access_cycles", acc, e.acc);
            chk("setup_cycles", setups, e.decerr ? 0 : 1);
            if (e.err) chk("err_first_cycle", {prev_rdy, prev_resp}, 3'b001);
            else if (!e.write) chk("hrdata", hrdata, e.rdata);
            void'(expq.pop_front());
            inflight = 0;
          end else if (lat > 100) begin
            n_vec++; n_bad++;
            $display("FAIL completion: hreadyout=%0b after %0d cycles, required 1", hreadyout, lat);
            void'(expq.pop_front());
            inflight = 0;
          end
        end
      end else begin
        chk("idle_outputs", {pselx != 0, penable, hresp, hreadyout}, 5'b00001);
      end
      if (hreadyin && hreadyout && htrans[1]) begin
        inflight = 1; lat = 0; acc = 0; setups = 0;
      end
      prev_rdy = hreadyout;
      prev_resp = hresp;
    end
  end

  initial begin : main
    int idx;
    int waits;
    repeat (2) @(posedge hclk);
    reset_check();
    @(posedge hclk) #1;
    hresetn = 1'b1;
    issue(32'h0000_1004, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
    issue(32'h0000_3000, 1'b1, 32'h1234_5678, 2, 1'b0, 32'h0BAD_0BAD);
    issue(32'h0000_5000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    issue(32'h0000_5000, 1'b1, 32'hA5A5_A5A5, 0, 1'b0, 32'h0);
    issue(32'h0000_2010, 1'b0, 32'h0, 0, 1'b1, 32'h5555_5555);
    issue(32'h0000_0020, 1'b1, 32'hCAFE_F00D, 0, 1'b0, 32'h0);
    issue(32'h0000_1000, 1'b0, 32'h0, 20, 1'b0, 32'h1);
    issue(32'h0000_2000, 1'b0, 32'h0, TO - 1, 1'b0, 32'h7777_0077);
    issue(32'h0000_F000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    for (int i = 0; i < 120; i++) begin
      idx = ($urandom_range(0, 7) == 0) ? $urandom_range(NS, 15) : $urandom_range(0, NS - 1);
      waits = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 3);
      issue(($urandom & 32'hFFFF_0FFF) | (32'(idx) << 12), 1'($urandom), $urandom, waits,
            $urandom_range(0, 5) == 0, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge hclk);
        #1;
      end
    end
    issue(32'h0000_1ABC, 1'b1, 32'h0BAD_F00D, 40, 1'b0, 32'h0);
    for (int i = 0; i < 50 && !penable; i++) @(negedge hclk);
    if (!penable) begin
      n_vec++; n_bad++;
      $display("FAIL reach_access: penable=%0b, required 1", penable);
    end
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b0;
    htrans = 2'b00;
    expq.delete();
    planq.delete();
    @(posedge hclk);
    reset_check();
    @(posedge hclk) #1;
    hresetn = 1'b1;
    issue(32'h0000_2008, 1'b0, 32'h0, 1, 1'b0, 32'hFEED_0001);
    issue(32'h0000_0000, 1'b1, 32'h0000_0001, 0, 1'b0, 32'h0);
    for (int i = 0; i < 200 && expq.size() != 0; i++) @(negedge hclk);
    if (expq.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain: %0d transfers outstanding, required 0", expq.size());
    end
    repeat (3) @(negedge hclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ahb2apb_bridge_gen2.md
AHB2APB_BRIDGE_GEN2 -- requirements
Module: ahb2apb_bridge_gen2

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of haddr/paddr.
REQ-002 Parameter DATA_WIDTH, default 32, width of hwdata/hrdata/pwdata/prdata.
REQ-003 Parameter NUM_SLAVES, default 4, number of APB slaves, range 1..16.
REQ-004 Parameter REGION_LSB, default 12, lowest haddr bit of the slave-index field.
REQ-005 Parameter TIMEOUT, default 16, maximum ACCESS cycles with pready low before abort.
REQ-006 Clock and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-007 hclk  in  1  bridge clock, all logic on rising edge.
REQ-008 hresetn  in  1  synchronous active-low reset.
REQ-009 hwrite  in  1  AHB transfer direction, 1 = write.
REQ-010 hreadyin  in  1  AHB bus ready from the interconnect.
REQ-011 htrans  in  2  AHB transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11).
REQ-012 haddr  in  ADDR_WIDTH  AHB address.
REQ-013 hwdata  in  DATA_WIDTH  AHB write data, valid in first data-phase cycle.
REQ-014 hrdata  out  DATA_WIDTH  AHB read data, registered.
REQ-015 hreadyout  out  1  bridge ready, registered.
REQ-016 hresp  out  2  response, 00 OKAY, 01 ERROR.
REQ-017 paddr  out  ADDR_WIDTH  APB address; pwrite out 1; pwdata out DATA_WIDTH; penable out 1.
REQ-018 pselx  out  NUM_SLAVES  one-hot APB slave select.
REQ-019 prdata  in  DATA_WIDTH; pready in 1; pslverr in 1, per APB3.

Function
REQ-020 A transfer SHALL be accepted when hreadyin=1, hreadyout=1 and htrans is NONSEQ or SEQ; haddr and hwrite are registered at acceptance.
REQ-021 Slave index = haddr[REGION_LSB+3:REGION_LSB]; an index >= NUM_SLAVES is a decode error.
REQ-022 FSM states: IDLE, WLATCH, SETUP, ACCESS, ERR1, ERR2.
REQ-023 IDLE: accepted write -> WLATCH; accepted read -> SETUP; decode error -> ERR1; else stay.
REQ-024 WLATCH (1 cycle): hwdata registered into pwdata -> SETUP.
REQ-025 SETUP (1 cycle): pselx one-hot, penable=0, paddr/pwrite/pwdata stable -> ACCESS.
REQ-026 ACCESS: penable=1; pready=1 and pslverr=0 -> IDLE with hreadyout=1, hresp=OKAY, hrdata=prdata (reads) on the next cycle.
REQ-027 ACCESS with pready=1 and pslverr=1 -> ERR1.
REQ-028 ACCESS with pready=0 for TIMEOUT consecutive cycles -> drop psel/penable, -> ERR1.
REQ-029 ERR1: hreadyout=0, hresp=ERROR; ERR2: hreadyout=1, hresp=ERROR; ERR2 -> IDLE, accepting a new transfer as in IDLE.
REQ-030 hreadyout SHALL be 0 from the cycle after acceptance until completion; htrans/haddr are ignored while hreadyout=0.
REQ-031 Minimum latency acceptance->hreadyout=1: read 3 cycles, write 4 cycles, zero APB wait states.
REQ-032 Timeout counter SHALL clear on entering ACCESS and saturate; pready sampled high at the limit cycle wins over timeout.
REQ-033 Decode-error transfers SHALL never assert any pselx bit.
REQ-034 BUSY/IDLE htrans SHALL always produce OKAY with no APB activity.

Reset
REQ-035 With hresetn=0 at a rising edge: state IDLE, hreadyout=1, hresp=00, pselx=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata=0, counter=0.
REQ-036 Reset mid-ACCESS SHALL abandon the APB transfer with no completion response.

Structure
REQ-037 Package ahb_apb_pkg SHALL hold htrans and hresp encodings and the FSM state enum.
REQ-038 Address decode SHALL be a sub-module ahb_apb_decoder (index -> one-hot + decode-error flag).

Verification
REQ-039 Read haddr=0x0000_1004, prdata=0xDEAD_BEEF, pready=1 -> pselx=0010, hrdata=0xDEAD_BEEF, OKAY 3 cycles after acceptance.
REQ-040 Write haddr=0x0000_3000, hwdata=0x1234_5678, pready low 2 cycles -> pselx=1000, pwdata=0x1234_5678 stable through SETUP/ACCESS, OKAY after 6 cycles.
REQ-041 Access haddr=0x0000_5000 (NUM_SLAVES=4) -> pselx stays 0, ERR1 then ERR2 with hresp=01.
REQ-042 pslverr=1 with pready=1 -> two-cycle ERROR response, then back-to-back NONSEQ accepted in ERR2.
REQ-043 pready held 0 with TIMEOUT=16 -> psel dropped after 16 ACCESS cycles, ERROR response.
REQ-044 hresetn=0 during ACCESS -> all outputs at reset values on the next edge, hreadyout=1.
